// File: rtl/axis_pkg.sv
// Shared helpers for the masked AXI-stream broadcaster: data width and clog2.
package axis_pkg;

    // tdata width in bits for a given byte count
    function automatic int unsigned axis_data_w(input int unsigned bytes);
        return bytes * 8;
    endfunction

    // Ceiling log2; used to size FIFO pointers
    function automatic int unsigned axis_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_fifo_lite.sv
// Small synchronous FIFO carrying AXI-stream beats (tdata + tlast).
// Writes are dropped while full (no write-through); the caller gates on full.
module axis_fifo_lite
    import axis_pkg::*;
#(
    parameter int unsigned AXIS_BYTES = 1,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned W         = axis_data_w(AXIS_BYTES)
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         in_tvalid,
    input  logic         in_tlast,
    input  logic [W-1:0] in_tdata,
    output logic         out_tvalid,
    input  logic         out_tready,
    output logic         out_tlast,
    output logic [W-1:0] out_tdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = axis_clog2(DEPTH);

    logic [W:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign full       = (r_count == (AW+1)'(DEPTH));
    assign empty      = (r_count == '0);
    assign w_wr       = in_tvalid & ~full;
    assign w_rd       = out_tready & ~empty;
    assign out_tvalid = ~empty;
    assign out_tlast  = r_mem[r_rptr][W];
    assign out_tdata  = r_mem[r_rptr][W-1:0];

    // Storage array; contents are don't-care while empty so it needs no reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {in_tlast, in_tdata};
        end
    end

    // Pointers wrap modulo DEPTH (power of 2); occupancy tracks full/empty
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axis_broadcaster_masked.sv
// Forks one AXI-stream input to NUM_STREAMS outputs under a per-packet mask.
// Optional macro AXIS_BCAST_STATS_EN adds per-output 16-bit delivered-packet counters.
module axis_broadcaster_masked
    import axis_pkg::*;
#(
    parameter int unsigned AXIS_BYTES  = 1,
    parameter int unsigned NUM_STREAMS = 2,
    parameter int unsigned DEPTH       = 4,
    localparam int unsigned W          = axis_data_w(AXIS_BYTES)
) (
    input  logic                     clk,
    input  logic                     aresetn,
    output logic                     axis_i_tready,
    input  logic                     axis_i_tvalid,
    input  logic                     axis_i_tlast,
    input  logic [W-1:0]             axis_i_tdata,
    input  logic [NUM_STREAMS-1:0]   axis_i_tmask,
    input  logic [NUM_STREAMS-1:0]   axis_o_tready,
    output logic [NUM_STREAMS-1:0]   axis_o_tvalid,
    output logic [NUM_STREAMS-1:0]   axis_o_tlast,
    output logic [NUM_STREAMS*W-1:0] axis_o_tdata,
    output logic [NUM_STREAMS*16-1:0] stat_pkts
);

    logic                   r_in_pkt;
    logic [NUM_STREAMS-1:0] r_held_mask;
    logic [NUM_STREAMS-1:0] w_sel;
    logic [NUM_STREAMS-1:0] w_full;
    logic [NUM_STREAMS-1:0] w_empty;
    logic [NUM_STREAMS-1:0] w_wr;
    logic                   w_ready;
    logic                   w_accept;

    // Mask is taken live on the first beat, then held for the rest of the packet
    assign w_sel    = r_in_pkt ? r_held_mask : axis_i_tmask;
    assign w_accept = axis_i_tvalid & w_ready;
    assign w_wr     = w_sel & {NUM_STREAMS{w_accept}};
    assign axis_i_tready = w_ready;

    // Stall only when some selected output has no room
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (w_sel[i] && w_full[i]) w_ready = 1'b0;
        end
    end

    // Packet tracking: first-beat state and latched destination mask
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_in_pkt    <= 1'b0;
            r_held_mask <= '0;
        end else if (w_accept) begin
            r_in_pkt <= ~axis_i_tlast;
            if (!r_in_pkt) r_held_mask <= axis_i_tmask;
        end
    end

    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_out
        axis_fifo_lite #(
            .AXIS_BYTES(AXIS_BYTES),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .aresetn   (aresetn),
            .in_tvalid (w_wr[i]),
            .in_tlast  (axis_i_tlast),
            .in_tdata  (axis_i_tdata),
            .out_tvalid(axis_o_tvalid[i]),
            .out_tready(axis_o_tready[i]),
            .out_tlast (axis_o_tlast[i]),
            .out_tdata (axis_o_tdata[(i+1)*W-1 -: W]),
            .full      (w_full[i]),
            .empty     (w_empty[i])
        );
    end

`ifdef AXIS_BCAST_STATS_EN
    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_stat
        logic [15:0] r_stat;

        // Count packets completed on this output; wraps at 0xFFFF
        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                r_stat <= '0;
            end else if (axis_o_tvalid[i] && axis_o_tready[i] && axis_o_tlast[i]) begin
                r_stat <= r_stat + 16'd1;
            end
        end

        assign stat_pkts[i*16 +: 16] = r_stat;
    end
`else
    assign stat_pkts = '0;
`endif

endmodule

// File: tb/tb_axis_broadcaster_masked.sv
// Directed self-checking bench for axis_broadcaster_masked (3 outputs, depth 4).
module tb_axis_broadcaster_masked;

    localparam int unsigned NS = 3;

    logic          clk;
    logic          aresetn;
    logic          i_tready;
    logic          i_tvalid;
    logic          i_tlast;
    logic [7:0]    i_tdata;
    logic [NS-1:0] i_tmask;
    logic [NS-1:0] o_tready;
    logic [NS-1:0] o_tvalid;
    logic [NS-1:0] o_tlast;
    logic [23:0]   o_tdata;
    logic [47:0]   stat;

    int total = 0;
    int bad   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [8:0] e[$];
    logic [8:0] none[$];
    int n;
    int waits;

    axis_broadcaster_masked #(
        .AXIS_BYTES (1),
        .NUM_STREAMS(NS),
        .DEPTH      (4)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .axis_i_tready(i_tready),
        .axis_i_tvalid(i_tvalid),
        .axis_i_tlast (i_tlast),
        .axis_i_tdata (i_tdata),
        .axis_i_tmask (i_tmask),
        .axis_o_tready(o_tready),
        .axis_o_tvalid(o_tvalid),
        .axis_o_tlast (o_tlast),
        .axis_o_tdata (o_tdata),
        .stat_pkts    (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every delivered beat per output as {tlast, tdata}
    always @(posedge clk) begin
        if (aresetn) begin
            if (o_tvalid[0] && o_tready[0]) q0.push_back({o_tlast[0], o_tdata[7:0]});
            if (o_tvalid[1] && o_tready[1]) q1.push_back({o_tlast[1], o_tdata[15:8]});
            if (o_tvalid[2] && o_tready[2]) q2.push_back({o_tlast[2], o_tdata[23:16]});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [8:0] got[$], input logic [8:0] exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check(tag, {23'd0, got[i]}, {23'd0, exp[i]});
        end
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following acceptance
    task automatic send(input logic [7:0] d, input logic last, input logic [2:0] mask,
                        output int waited);
        waited   = 0;
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tlast  = last;
        i_tmask  = mask;
        #1;
        while (!i_tready) begin
            @(negedge clk);
            #1;
            waited++;
            if (waited > 200) begin
                $display("FAIL send_timeout: got stalled expected accept");
                $fatal(1, "input never ready");
            end
        end
        @(posedge clk);
        @(negedge clk);
        i_tvalid = 1'b0;
    endtask

    initial begin
        aresetn  = 1'b0;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tdata  = 8'h00;
        i_tmask  = 3'b000;
        o_tready = 3'b111;
        none     = {};
        idle(2);
        check("rst_tvalid", o_tvalid, 3'b000);
        check("rst_tready", i_tready, 1'b1);
        check("rst_stat", stat, 48'd0);
        aresetn = 1'b1;
        idle(1);

        // 1: basic fork to outputs 0 and 2, one-cycle latency
        clear_q();
        send(8'h11, 1'b0, 3'b101, n);
        check("t1_v_b1", o_tvalid, 3'b101);
        check("t1_d0_b1", o_tdata[7:0], 8'h11);
        check("t1_d2_b1", o_tdata[23:16], 8'h11);
        send(8'h22, 1'b0, 3'b101, n);
        check("t1_d0_b2", o_tdata[7:0], 8'h22);
        check("t1_v_b2", o_tvalid, 3'b101);
        send(8'h33, 1'b1, 3'b101, n);
        check("t1_d2_b3", o_tdata[23:16], 8'h33);
        check("t1_last_b3", o_tlast & o_tvalid, 3'b101);
        idle(1);
        check("t1_v_after", o_tvalid, 3'b000);
        e = '{9'h011, 9'h022, 9'h133};
        check_q("t1_q0", q0, e);
        check_q("t1_q1", q1, none);
        check_q("t1_q2", q2, e);

        // 2: mask change mid-packet is ignored
        clear_q();
        send(8'hA1, 1'b0, 3'b001, n);
        send(8'hA2, 1'b0, 3'b110, n);
        send(8'hA3, 1'b1, 3'b110, n);
        idle(3);
        e = '{9'h0A1, 9'h0A2, 9'h1A3};
        check_q("t2_q0", q0, e);
        check_q("t2_q1", q1, none);
        check_q("t2_q2", q2, none);

        // 3: stalled selected output back-pressures after DEPTH beats
        clear_q();
        o_tready = 3'b101;
        waits = 0;
        for (int k = 1; k <= 4; k++) begin
            send(8'hB0 + 8'(k), 1'b0, 3'b011, n);
            waits += n;
        end
        check("t3_nowait_1to4", waits, 0);
        i_tvalid = 1'b1;
        i_tdata  = 8'hB5;
        i_tlast  = 1'b0;
        #1;
        check("t3_stall_a", i_tready, 1'b0);
        @(negedge clk);
        #1;
        check("t3_stall_b", i_tready, 1'b0);
        check("t3_v1_held", o_tvalid[1], 1'b1);
        check("t3_d1_held", o_tdata[15:8], 8'hB1);
        check("t3_q0_len_stalled", q0.size(), 4);
        @(negedge clk);
        o_tready = 3'b111;
        send(8'hB5, 1'b0, 3'b011, n);
        send(8'hB6, 1'b1, 3'b011, n);
        idle(8);
        e = '{9'h0B1, 9'h0B2, 9'h0B3, 9'h0B4, 9'h0B5, 9'h1B6};
        check_q("t3_q0", q0, e);
        check_q("t3_q1", q1, e);
        check_q("t3_q2", q2, none);

        // 4: full but unselected output does not stall
        clear_q();
        o_tready = 3'b101;
        send(8'hC1, 1'b0, 3'b010, n);
        send(8'hC2, 1'b0, 3'b010, n);
        send(8'hC3, 1'b0, 3'b010, n);
        send(8'hC4, 1'b1, 3'b010, n);
        send(8'hD1, 1'b0, 3'b001, n);
        check("t4_nowait_d1", n, 0);
        send(8'hD2, 1'b1, 3'b001, n);
        check("t4_nowait_d2", n, 0);
        idle(3);
        e = '{9'h0D1, 9'h1D2};
        check_q("t4_q0", q0, e);
        check("t4_v1_pending", o_tvalid[1], 1'b1);
        o_tready = 3'b111;
        idle(8);
        e = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4};
        check_q("t4_q1", q1, e);

        // 5: mask 0 discards at full rate, next packet delivered normally
        clear_q();
        waits = 0;
        for (int k = 1; k <= 5; k++) begin
            send(8'hE0 + 8'(k), (k == 5), 3'b000, n);
            waits += n;
            check("t5_no_valid", o_tvalid, 3'b000);
        end
        check("t5_full_rate", waits, 0);
        send(8'hF1, 1'b0, 3'b111, n);
        send(8'hF2, 1'b1, 3'b111, n);
        idle(4);
        e = '{9'h0F1, 9'h1F2};
        check_q("t5_q0", q0, e);
        check_q("t5_q1", q1, e);
        check_q("t5_q2", q2, e);
`ifdef AXIS_BCAST_STATS_EN
        check("t5_stat0", stat[15:0], 16'd5);
        check("t5_stat1", stat[31:16], 16'd3);
        check("t5_stat2", stat[47:32], 16'd2);
`else
        check("t5_stat_tied", stat, 48'd0);
`endif

        // 6: reset mid-packet flushes FIFOs and restarts at first-beat state
        clear_q();
        o_tready = 3'b000;
        send(8'h61, 1'b0, 3'b011, n);
        send(8'h62, 1'b0, 3'b011, n);
        check("t6_v_before", o_tvalid, 3'b011);
        aresetn = 1'b0;
        #1;
        check("t6_v_in_reset", o_tvalid, 3'b000);
        check("t6_stat_in_reset", stat, 48'd0);
        @(negedge clk);
        aresetn  = 1'b1;
        o_tready = 3'b111;
        clear_q();
        send(8'h71, 1'b1, 3'b100, n);
        idle(3);
        e = '{9'h171};
        check_q("t6_q2", q2, e);
        check_q("t6_q0", q0, none);
        check_q("t6_q1", q1, none);
        for (int k = 1; k <= 3; k++) begin
            send(8'h80 + 8'(k), 1'b1, 3'b001, n);
        end
        idle(3);
        e = '{9'h181, 9'h182, 9'h183};
        check_q("t6_q0_pkts", q0, e);
`ifdef AXIS_BCAST_STATS_EN
        check("t6_stat0", stat[15:0], 16'd3);
        check("t6_stat1", stat[31:16], 16'd0);
        check("t6_stat2", stat[47:32], 16'd1);
`else
        check("t6_stat_tied", stat, 48'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
